// File: rtl/wb_arbiter_pkg.sv
// Shared writeback defines: pipe count/IDs, register index width, buffer depth
// and the register-file write grouping.
package wb_arbiter_pkg;
    localparam int NUM_EXE_PIPES = 4;
    localparam int EXE_PIPE_ID_0 = 0;
    localparam int EXE_PIPE_ID_1 = 1;
    localparam int EXE_PIPE_ID_2 = 2;
    localparam int EXE_PIPE_ID_3 = 3;
    localparam int REG_WIDTH     = 5;
    localparam int XLEN          = 32;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                 wr_en;
        logic [REG_WIDTH-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_ix_inf_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Pipe-to-writeback bus: per-pipe result handshake in, register-file write out.
interface wb_arbiter_if #(
    parameter int NUM_PIPES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
);
    logic [NUM_PIPES-1:0]            pipe_valid;
    logic [NUM_PIPES-1:0]            pipe_ready;
    logic [NUM_PIPES-1:0]            pipe_wr_en;
    logic [NUM_PIPES*REG_WIDTH-1:0]  pipe_rd;
    logic [NUM_PIPES*DATA_WIDTH-1:0] pipe_data;
    logic                            wb_wr_en;
    logic [REG_WIDTH-1:0]            wb_rd;
    logic [DATA_WIDTH-1:0]           wb_wr_data;
    logic [NUM_PIPES-1:0]            wb_grant;

    modport slave (
        input  pipe_valid, pipe_wr_en, pipe_rd, pipe_data,
        output pipe_ready, wb_wr_en, wb_rd, wb_wr_data, wb_grant
    );
    modport master (
        output pipe_valid, pipe_wr_en, pipe_rd, pipe_data,
        input  pipe_ready, wb_wr_en, wb_rd, wb_wr_data, wb_grant
    );
endinterface

// File: rtl/wb_fifo.sv
// Per-pipe writeback buffer. Ready is !full only: a same-cycle pop does not
// open a slot for the push, keeping the ready path free of arbiter logic.
module wb_fifo import wb_arbiter_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = wb_arbiter_pkg::REG_WIDTH,
    parameter int DEPTH      = WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_wr_en,
    input  logic [REG_WIDTH-1:0]  i_rd,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_ready,
    output logic                  o_empty,
    output logic                  o_wr_en,
    output logic [REG_WIDTH-1:0]  o_rd,
    output logic [DATA_WIDTH-1:0] o_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + REG_WIDTH + DATA_WIDTH;

    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic             w_full, w_push, w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_ready = !w_full;
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign {o_wr_en, o_rd, o_data} = r_mem[r_rptr];

    // DEPTH is a power of two, so pointer wrap is natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {i_wr_en, i_rd, i_data};
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers each exe pipe's results and retires one per cycle
// into the register file. Fixed priority by default; WB_ARB_RR_EN selects round-robin.
module wb_arbiter import wb_arbiter_pkg::*; #(
    parameter int NUM_PIPES  = NUM_EXE_PIPES,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = wb_arbiter_pkg::REG_WIDTH,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);
    localparam int SEL_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    logic [NUM_PIPES-1:0]  w_empty;
    logic [NUM_PIPES-1:0]  w_pop;
    logic                  w_head_we   [NUM_PIPES];
    logic [REG_WIDTH-1:0]  w_head_rd   [NUM_PIPES];
    logic [DATA_WIDTH-1:0] w_head_data [NUM_PIPES];
    logic                  w_sel_vld;
    logic [SEL_W-1:0]      w_sel;

    logic                  r_wr_en;
    logic [REG_WIDTH-1:0]  r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NUM_PIPES-1:0]  r_grant;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        wb_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_WIDTH  (REG_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (bus.pipe_valid[i]),
            .i_wr_en (bus.pipe_wr_en[i]),
            .i_rd    (bus.pipe_rd[i*REG_WIDTH +: REG_WIDTH]),
            .i_data  (bus.pipe_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_pop   (w_pop[i]),
            .o_ready (bus.pipe_ready[i]),
            .o_empty (w_empty[i]),
            .o_wr_en (w_head_we[i]),
            .o_rd    (w_head_rd[i]),
            .o_data  (w_head_data[i])
        );
        assign w_pop[i] = w_sel_vld && (w_sel == SEL_W'(i));
    end

`ifdef WB_ARB_RR_EN
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_cand;

    // Search begins one past the last granted pipe
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_PIPES; k++) begin
            w_cand = SEL_W'((int'(r_rr_ptr) + k) % NUM_PIPES);
            if (!w_sel_vld && !w_empty[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel     = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_rr_ptr <= SEL_W'(NUM_PIPES - 1);
        else if (w_sel_vld) r_rr_ptr <= w_sel;
    end
`else
    // Descending scan so the lowest non-empty index is the final assignment
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (!w_empty[i]) begin
                w_sel_vld = 1'b1;
                w_sel     = SEL_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_grant <= '0;
        end else begin
            r_grant <= w_pop;
            if (w_sel_vld) begin
                r_wr_en <= w_head_we[w_sel] && (w_head_rd[w_sel] != '0);
                r_rd    <= w_head_rd[w_sel];
                r_data  <= w_head_data[w_sel];
            end else begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign bus.wb_wr_en   = r_wr_en;
    assign bus.wb_rd      = r_rd;
    assign bus.wb_wr_data = r_data;
    assign bus.wb_grant   = r_grant;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, priority, backpressure, x0 suppression, async reset.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_PIPES(4), .DATA_WIDTH(32), .REG_WIDTH(5)) bus ();

    wb_arbiter #(
        .NUM_PIPES  (4),
        .DATA_WIDTH (32),
        .REG_WIDTH  (5),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pipe(input int p, input logic v, input logic we,
                            input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid[p]        = v;
        bus.pipe_wr_en[p]        = we;
        bus.pipe_rd[p*5 +: 5]    = rd;
        bus.pipe_data[p*32 +: 32] = d;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [3:0] g,
                             input logic [4:0] rd, input logic [31:0] d);
        check({tag, "_we"},   32'(bus.wb_wr_en),   32'(we));
        check({tag, "_gnt"},  32'(bus.wb_grant),   32'(g));
        check({tag, "_rd"},   32'(bus.wb_rd),      32'(rd));
        check({tag, "_data"}, bus.wb_wr_data,      d);
    endtask

    initial begin
        bus.pipe_valid = '0;
        bus.pipe_wr_en = '0;
        bus.pipe_rd    = '0;
        bus.pipe_data  = '0;

        // reset state
        tick();
        tick();
        check_out("rst", 1'b0, 4'b0000, 5'd0, 32'h0);
        check("rst_ready", 32'(bus.pipe_ready), 32'hF);
        rst = 1'b0;

        // single push, two-cycle latency, then hold with no pop
        set_pipe(2, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        set_pipe(2, 1'b0, 1'b0, 5'd0, 32'h0);
        check("lat_c1_gnt", 32'(bus.wb_grant), 32'h0);
        tick();
        check_out("lat_c2", 1'b1, 4'b0100, 5'd7, 32'hDEADBEEF);
        tick();
        check_out("idle_hold", 1'b0, 4'b0000, 5'd7, 32'hDEADBEEF);

        // simultaneous pushes on pipes 0 and 3
        set_pipe(0, 1'b1, 1'b1, 5'd1, 32'h11);
        set_pipe(3, 1'b1, 1'b1, 5'd3, 32'h33);
        tick();
        set_pipe(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_pipe(3, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
`ifdef WB_ARB_RR_EN
        check_out("pri_first", 1'b1, 4'b1000, 5'd3, 32'h33);
        tick();
        check_out("pri_second", 1'b1, 4'b0001, 5'd1, 32'h11);
`else
        check_out("pri_first", 1'b1, 4'b0001, 5'd1, 32'h11);
        tick();
        check_out("pri_second", 1'b1, 4'b1000, 5'd3, 32'h33);
`endif
        tick();

        // write to x0 is retired but suppressed
        set_pipe(1, 1'b1, 1'b1, 5'd0, 32'h5);
        tick();
        set_pipe(1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check_out("x0", 1'b0, 4'b0010, 5'd0, 32'h5);
        tick();

`ifndef WB_ARB_RR_EN
        // pipe 0 hogs priority while pipe 1 fills its buffer
        set_pipe(0, 1'b1, 1'b1, 5'd20, 32'h20);
        set_pipe(1, 1'b1, 1'b1, 5'd10, 32'hA1);
        tick();
        set_pipe(1, 1'b1, 1'b1, 5'd11, 32'hB1);
        tick();
        check("ovf_full", 32'(bus.pipe_ready[1]), 32'h0);
        set_pipe(1, 1'b1, 1'b1, 5'd12, 32'hC1);
        set_pipe(0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check("ovf_nopt", 32'(bus.pipe_ready[1]), 32'h0);
        check_out("ovf_p0", 1'b1, 4'b0001, 5'd20, 32'h20);
        tick();
        check("ovf_ready", 32'(bus.pipe_ready[1]), 32'h1);
        check_out("ovf_a", 1'b1, 4'b0010, 5'd10, 32'hA1);
        tick();
        set_pipe(1, 1'b0, 1'b0, 5'd0, 32'h0);
        check_out("ovf_b", 1'b1, 4'b0010, 5'd11, 32'hB1);
        tick();
        check_out("ovf_c", 1'b1, 4'b0010, 5'd12, 32'hC1);
        tick();
`endif

        // all four pipes held valid for eight cycles
        pulse_rst();
        for (int p = 0; p < 4; p++) set_pipe(p, 1'b1, 1'b1, 5'(p + 1), 32'(p));
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
`ifdef WB_ARB_RR_EN
            check($sformatf("all_gnt%0d", k), 32'(bus.wb_grant), 32'(4'b0001 << (k % 4)));
`else
            check($sformatf("all_gnt%0d", k), 32'(bus.wb_grant), 32'h1);
`endif
            tick();
        end
        for (int p = 0; p < 4; p++) set_pipe(p, 1'b0, 1'b0, 5'd0, 32'h0);

        // async reset with entries buffered
        pulse_rst();
        set_pipe(0, 1'b1, 1'b1, 5'd4, 32'h44);
        set_pipe(1, 1'b1, 1'b1, 5'd9, 32'h99);
        tick();
        tick();
        set_pipe(0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_pipe(1, 1'b0, 1'b0, 5'd0, 32'h0);
        check_out("pre_rst", 1'b1, 4'b0001, 5'd4, 32'h44);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 4'b0000, 5'd0, 32'h0);
        check("async_ready", 32'(bus.pipe_ready), 32'hF);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst_gnt%0d", k), 32'(bus.wb_grant), 32'h0);
            check($sformatf("post_rst_we%0d", k), 32'(bus.wb_wr_en), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 4 (NUM_EXE_PIPES), number of execution pipes feeding writeback.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result width.
REQ-003 SHALL have parameter REG_WIDTH, default 5, destination register index width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, per-pipe buffer entries; power of two, at least 2.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pipe_valid  in  NUM_PIPES  per-pipe result valid.
REQ-008 SHALL have port pipe_ready  out  NUM_PIPES  per-pipe buffer not full.
REQ-009 SHALL have port pipe_wr_en  in  NUM_PIPES  per-pipe register_write flag.
REQ-010 SHALL have port pipe_rd  in  NUM_PIPES*REG_WIDTH  per-pipe destination register, pipe i at slice i.
REQ-011 SHALL have port pipe_data  in  NUM_PIPES*DATA_WIDTH  per-pipe result, pipe i at slice i.
REQ-012 SHALL have port wb_wr_en  out  1  register-file write enable.
REQ-013 SHALL have port wb_rd  out  REG_WIDTH  register-file write index.
REQ-014 SHALL have port wb_wr_data  out  DATA_WIDTH  register-file write data.
REQ-015 SHALL have port wb_grant  out  NUM_PIPES  one-hot pipe retired this cycle; all-zero when none.

Function
REQ-016 SHALL hold one FIFO per pipe; a push occurs when pipe_valid[i] and pipe_ready[i] are both high.
REQ-017 SHALL drive pipe_ready[i] = !full[i]; no pop-through, so ready is low when full even if that FIFO is popped this cycle.
REQ-018 SHALL track per-FIFO read/write pointers modulo FIFO_DEPTH and an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-019 SHALL each cycle select at most one non-empty FIFO and pop its head at the clock edge.
REQ-020 SHALL use fixed priority (lowest pipe index wins, matching EXE_PIPE_ID order) when WB_ARB_RR_EN is undefined.
REQ-021 SHALL register the popped entry onto wb_rd/wb_wr_data/wb_grant; latency is 2 cycles from the push cycle to the output cycle when uncontended.
REQ-022 SHALL drive wb_wr_en = popped wr_en AND (popped rd != 0); x0 writes are retired but suppressed.
REQ-023 SHALL, in a cycle with no pop, drive wb_wr_en=0 and wb_grant=0, and hold wb_rd and wb_wr_data.
REQ-024 SHALL allow a push and a pop on the same FIFO in one cycle, leaving occupancy unchanged.
REQ-025 SHALL preserve per-pipe order; cross-pipe order is arbitration order only.
REQ-026 SHALL treat fixed-priority starvation of higher indices as permitted behaviour.

Reset
REQ-027 SHALL, on rst assertion, immediately clear all pointers and counters, drop in-flight entries, and drive wb_wr_en=0, wb_rd=0, wb_wr_data=0, wb_grant=0.
REQ-028 SHALL drive pipe_ready all-ones during and after reset, and set the round-robin pointer to NUM_PIPES-1.

Configuration
REQ-029 SHALL, with macro WB_ARB_RR_EN defined, arbitrate round-robin: search starts at the index after the last granted pipe, and the pointer updates only on a grant.
REQ-030 SHALL, without WB_ARB_RR_EN, contain no round-robin state and use fixed priority per REQ-020.

Structure
REQ-031 SHALL take NUM_EXE_PIPES, EXE_PIPE_ID_*, REG_WIDTH and the wb_ix_inf_t output grouping from the shared defines package.
REQ-032 SHALL add localparam WB_FIFO_DEPTH = 2 to the shared defines package.
REQ-033 SHALL instantiate the per-pipe buffer as sub-module wb_fifo, NUM_PIPES times.

Verification
REQ-034 SHALL cover: push pipe 2 rd=7 data=0xDEADBEEF wr_en=1 in cycle 0 -> cycle 2 outputs wb_wr_en=1, wb_rd=7, wb_wr_data=0xDEADBEEF, wb_grant=0100.
REQ-035 SHALL cover: pipes 0 and 3 push simultaneously, fixed priority -> pipe 0 retires first, pipe 3 next cycle.
REQ-036 SHALL cover: with WB_ARB_RR_EN, all 4 pipes held valid for 8 cycles -> grants rotate 0,1,2,3,0,1,2,3.
REQ-037 SHALL cover: pipe 1 pushes 3 entries, FIFO_DEPTH=2, pipe 0 holding priority -> pipe_ready[1]=0 after 2 pushes; 3rd accepted after first pop; order preserved.
REQ-038 SHALL cover: push rd=0 wr_en=1 -> wb_grant set, wb_wr_en=0.
REQ-039 SHALL cover: rst asserted with 2 entries buffered -> outputs zero without waiting for a clock edge; no stale entry appears after release.
